// File: rtl/uart_rx_monitor.sv
// 8N1 serial receiver feeding a first-word-fall-through byte FIFO.
// Listens on the SoC transmit line; the simulation top pops received bytes.
module uart_rx_monitor #(
  parameter int CLOCKS_PER_BIT = 416,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          sourceClk,
  input  logic                          reset,
  input  logic                          rx_in,
  input  logic                          rd_en,
  input  logic                          clear_errors,
  output logic [7:0]                    rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          byte_valid,
  output logic                          framing_error,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_V  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic          sync1, rxs;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          good_byte, frame_bad;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, occ_n;
  logic          pop, push, ovf_set;
  logic [7:0]    head_n;

  always_ff @(posedge sourceClk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge sourceClk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    good_byte = 1'b0;
    frame_bad = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rxs ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          shreg_n   = {rxs, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          state_n   = IDLE;
          good_byte = rxs;
          frame_bad = !rxs;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
  always_comb begin
    pop      = rd_en && !empty;
    push     = good_byte && (!full || pop);
    ovf_set  = good_byte && full && !pop;
    wr_ptr_n = wr_ptr + (AW + 1)'(push);
    rd_ptr_n = rd_ptr + (AW + 1)'(pop);
    occ_n    = wr_ptr_n - rd_ptr_n;
    // Registered head: bypass the byte being written when it becomes the new head.
    if (push && (rd_ptr_n[AW-1:0] == wr_ptr[AW-1:0]))
      head_n = shreg;
    else
      head_n = mem[rd_ptr_n[AW-1:0]];
  end

  always_ff @(posedge sourceClk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge sourceClk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      rd_data       <= '0;
      empty         <= 1'b1;
      full          <= 1'b0;
      count         <= '0;
      byte_valid    <= 1'b0;
      framing_error <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      rd_data    <= head_n;
      empty      <= (occ_n == '0);
      full       <= (occ_n == DEPTH_V);
      count      <= occ_n;
      byte_valid <= push;
      if (frame_bad)         framing_error <= 1'b1;
      else if (clear_errors) framing_error <= 1'b0;
      if (ovf_set)           overflow <= 1'b1;
      else if (clear_errors) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor at 16 clocks per bit, 8-entry FIFO.
module tb_uart_rx_monitor;

  localparam int CPB = 16;

  logic       sourceClk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_in = 1'b1;
  logic       rd_man = 1'b0;
  logic       rd_en;
  logic       clear_errors = 1'b0;
  logic       auto_pop = 1'b0;
  logic [7:0] rd_data;
  logic       empty, full, byte_valid, framing_error, overflow;
  logic [3:0] count;

  int tests = 0;
  int fails = 0;
  int bv_total = 0;
  int pop_n = 0;
  int over_cnt = 0;
  logic [7:0] pop_log [16];

  always #5 sourceClk = ~sourceClk;

  assign rd_en = rd_man | (auto_pop & byte_valid);

  uart_rx_monitor #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .sourceClk(sourceClk), .reset(reset), .rx_in(rx_in), .rd_en(rd_en),
    .clear_errors(clear_errors), .rd_data(rd_data), .empty(empty), .full(full),
    .count(count), .byte_valid(byte_valid), .framing_error(framing_error),
    .overflow(overflow)
  );

  always @(negedge sourceClk) begin
    if (byte_valid) bv_total++;
    if (auto_pop && byte_valid) begin
      pop_log[pop_n % 16] = rd_data;
      pop_n++;
    end
    if (auto_pop && count > 4'd1) over_cnt++;
  end

  task automatic send_byte(input logic [7:0] data, input logic stop_bit);
    rx_in = 1'b0;
    repeat (CPB) @(negedge sourceClk);
    for (int i = 0; i < 8; i++) begin
      rx_in = data[i];
      repeat (CPB) @(negedge sourceClk);
    end
    rx_in = stop_bit;
    repeat (CPB) @(negedge sourceClk);
    rx_in = 1'b1;
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    @(negedge sourceClk);
    clear_errors = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    tests++; if (rd_data !== 8'h00) begin fails++; $display("FAIL %s rd_data: got %h expected 00", tag, rd_data); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL %s empty: got %b expected 1", tag, empty); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL %s full: got %b expected 0", tag, full); end
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL %s count: got %0d expected 0", tag, count); end
    tests++; if (byte_valid !== 1'b0) begin fails++; $display("FAIL %s byte_valid: got %b expected 0", tag, byte_valid); end
    tests++; if (framing_error !== 1'b0) begin fails++; $display("FAIL %s framing_error: got %b expected 0", tag, framing_error); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL %s overflow: got %b expected 0", tag, overflow); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge sourceClk);
    check_reset_state("reset");
    reset = 1'b0;
    repeat (4) @(negedge sourceClk);
  endtask

  task automatic test_single();
    int bv0 = bv_total;
    send_byte(8'h62, 1'b1);
    tests++; if (bv_total - bv0 !== 1) begin fails++; $display("FAIL single pulses: got %0d expected 1", bv_total - bv0); end
    tests++; if (rd_data !== 8'h62) begin fails++; $display("FAIL single rd_data: got %h expected 62", rd_data); end
    tests++; if (count !== 4'd1) begin fails++; $display("FAIL single count: got %0d expected 1", count); end
    tests++; if (empty !== 1'b0) begin fails++; $display("FAIL single empty: got %b expected 0", empty); end
    rd_man = 1'b1;
    @(negedge sourceClk);
    rd_man = 1'b0;
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL single empty after pop: got %b expected 1", empty); end
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL single count after pop: got %0d expected 0", count); end
  endtask

  task automatic test_framing();
    int bv0 = bv_total;
    send_byte(8'hA5, 1'b0);
    repeat (30) @(negedge sourceClk);
    tests++; if (framing_error !== 1'b1) begin fails++; $display("FAIL framing flag: got %b expected 1", framing_error); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL framing empty: got %b expected 1", empty); end
    tests++; if (bv_total - bv0 !== 0) begin fails++; $display("FAIL framing pulses: got %0d expected 0", bv_total - bv0); end
    pulse_clear();
    tests++; if (framing_error !== 1'b0) begin fails++; $display("FAIL framing clear: got %b expected 0", framing_error); end
  endtask

  task automatic test_glitch();
    int bv0 = bv_total;
    rx_in = 1'b0;
    repeat (4) @(negedge sourceClk);
    rx_in = 1'b1;
    repeat (40) @(negedge sourceClk);
    tests++; if (bv_total - bv0 !== 0) begin fails++; $display("FAIL glitch pulses: got %0d expected 0", bv_total - bv0); end
    tests++; if (framing_error !== 1'b0 || overflow !== 1'b0) begin fails++; $display("FAIL glitch flags: got %b%b expected 00", framing_error, overflow); end
    // A following clean frame shows the receiver is back in idle.
    send_byte(8'h5A, 1'b1);
    tests++; if (rd_data !== 8'h5A || count !== 4'd1) begin fails++; $display("FAIL glitch recover: got %h/%0d expected 5a/1", rd_data, count); end
    rd_man = 1'b1;
    @(negedge sourceClk);
    rd_man = 1'b0;
  endtask

  task automatic test_overflow();
    int bv0 = bv_total;
    for (int i = 0; i < 8; i++) send_byte(8'(i), 1'b1);
    tests++; if (full !== 1'b1 || overflow !== 1'b0) begin fails++; $display("FAIL ovf full before 9th: got full=%b ovf=%b expected 1/0", full, overflow); end
    send_byte(8'h08, 1'b1);
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL ovf full: got %b expected 1", full); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf flag: got %b expected 1", overflow); end
    tests++; if (count !== 4'd8) begin fails++; $display("FAIL ovf count: got %0d expected 8", count); end
    tests++; if (bv_total - bv0 !== 8) begin fails++; $display("FAIL ovf pulses: got %0d expected 8", bv_total - bv0); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (rd_data !== 8'(i)) begin fails++; $display("FAIL ovf pop %0d: got %h expected %h", i, rd_data, 8'(i)); end
      rd_man = 1'b1;
      @(negedge sourceClk);
      rd_man = 1'b0;
    end
    tests++; if (empty !== 1'b1 || full !== 1'b0) begin fails++; $display("FAIL ovf drained: got empty=%b full=%b expected 1/0", empty, full); end
    pulse_clear();
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf clear: got %b expected 0", overflow); end
  endtask

  task automatic test_back_to_back();
    int bv0 = bv_total;
    int p0 = pop_n;
    int o0 = over_cnt;
    auto_pop = 1'b1;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    repeat (4) @(negedge sourceClk);
    auto_pop = 1'b0;
    tests++; if (pop_n - p0 !== 2) begin fails++; $display("FAIL b2b pops: got %0d expected 2", pop_n - p0); end
    tests++; if (pop_log[p0 % 16] !== 8'h00) begin fails++; $display("FAIL b2b byte0: got %h expected 00", pop_log[p0 % 16]); end
    tests++; if (pop_log[(p0 + 1) % 16] !== 8'hFF) begin fails++; $display("FAIL b2b byte1: got %h expected ff", pop_log[(p0 + 1) % 16]); end
    tests++; if (over_cnt - o0 !== 0) begin fails++; $display("FAIL b2b count>1 cycles: got %0d expected 0", over_cnt - o0); end
    tests++; if (bv_total - bv0 !== 2) begin fails++; $display("FAIL b2b pulses: got %0d expected 2", bv_total - bv0); end
    tests++; if (framing_error !== 1'b0 || overflow !== 1'b0 || empty !== 1'b1) begin fails++; $display("FAIL b2b end state: got fe=%b ovf=%b empty=%b expected 0/0/1", framing_error, overflow, empty); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d = 8'h3C;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    repeat (20) @(negedge sourceClk);
    tests++; if (count !== 4'd1 || framing_error !== 1'b1) begin fails++; $display("FAIL midreset setup: got count=%0d fe=%b expected 1/1", count, framing_error); end
    rx_in = 1'b0;
    repeat (CPB) @(negedge sourceClk);
    for (int i = 0; i < 4; i++) begin
      rx_in = d[i];
      repeat (CPB) @(negedge sourceClk);
    end
    rx_in = d[4];
    repeat (CPB / 2) @(negedge sourceClk);
    reset = 1'b1;
    rx_in = 1'b1;
    repeat (2) @(negedge sourceClk);
    check_reset_state("midreset");
    reset = 1'b0;
    repeat (4 * CPB) @(negedge sourceClk);
    tests++; if (empty !== 1'b1 || framing_error !== 1'b0) begin fails++; $display("FAIL midreset partial: got empty=%b fe=%b expected 1/0", empty, framing_error); end
    send_byte(8'h3C, 1'b1);
    tests++; if (rd_data !== 8'h3C || count !== 4'd1) begin fails++; $display("FAIL midreset next frame: got %h/%0d expected 3c/1", rd_data, count); end
  endtask

  initial begin
    @(negedge sourceClk);
    test_reset();
    test_single();
    test_framing();
    test_glitch();
    test_overflow();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_monitor.md
# uart_rx_monitor

Simulation-side serial receiver that acts as the "Go client" listening end. It consumes the SoC's `uart_tx_out` line, deserializes 8N1 frames and buffers the received bytes in a small first-word-fall-through FIFO. The simulation top pops those bytes to check SoC responses. Its companion block is the client `UARTTx`, which drives the SoC's `uart_rx_in`.

## Interface
Parameters:
- `CLOCKS_PER_BIT`, default 416: sourceClk cycles per bit (48 MHz / 115200); minimum 4.
- `FIFO_DEPTH`, default 8: byte entries; power of two.

Ports:
- `sourceClk`  in  1  single clock for all logic.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `rx_in`  in  1  serial line from SoC `uart_tx_out`; idle high.
- `rd_en`  in  1  pop head byte when `empty`=0.
- `clear_errors`  in  1  synchronous clear of the sticky error flags.
- `rd_data`  out  8  FIFO head byte, valid while `empty`=0; reset 8'h00.
- `empty`  out  1  FIFO empty; reset 1.
- `full`  out  1  FIFO full; reset 0.
- `count`  out  $clog2(FIFO_DEPTH)+1  occupancy; reset 0.
- `byte_valid`  out  1  one-cycle pulse when a byte is written into the FIFO; reset 0.
- `framing_error`  out  1  sticky, set when a stop bit is sampled as 0; reset 0.
- `overflow`  out  1  sticky, set when a good byte arrives while the FIFO is full; reset 0.

## Operation
- `rx_in` passes through a 2-flop synchronizer whose flops reset to 1. `rxs` denotes the synchronizer output.
- `HALF` = CLOCKS_PER_BIT/2, using integer division. A bit counter `cnt` is wide enough for CLOCKS_PER_BIT-1.
- Receiver FSM states are IDLE, START, DATA and STOP. The FSM resets to IDLE.
  - IDLE: when `rxs`=0, go to START with `cnt`=0.
  - START: increment `cnt`. When `cnt`=HALF-1, sample `rxs`.
    - If the sample is 0, go to DATA with `cnt`=0 and `bitIdx`=0.
    - If the sample is 1, treat it as a glitch: return to IDLE, no flag.
  - DATA: when `cnt`=CLOCKS_PER_BIT-1, shift `rxs` into the shift register LSB first, set `cnt`=0 and increment `bitIdx`. After the 8th sample, go to STOP.
  - STOP: when `cnt`=CLOCKS_PER_BIT-1, sample `rxs` and return to IDLE.
    - If the sample is 1, push the byte. If the FIFO is full, drop the byte and set `overflow`.
    - If the sample is 0, discard the byte and set `framing_error`.
- FIFO: circular buffer with `FIFO_DEPTH` entries. Read and write pointers are one bit wider than the address, so full and empty are distinguishable at wrap-around.
  - `rd_en` while empty is ignored.
  - A push and a pop in the same cycle while full both take effect: `count` is unchanged and `overflow` is not set.
  - A push and a pop in the same cycle while empty: the push happens and the pop is ignored.
- `clear_errors` clears both sticky flags in the next cycle. If a set event occurs in the same cycle as `clear_errors`, the set wins.
- A reset mid-frame returns the FSM to IDLE, empties the FIFO and clears the flags. The partial byte is lost.

## Timing
- Synchronizer latency: 2 cycles from `rx_in` to `rxs`.
- The start-bit check occurs HALF cycles after IDLE sees `rxs`=0.
- Data bit n (0..7) is sampled (n+1)·CLOCKS_PER_BIT cycles after the start-bit check.
- The stop sample occurs 9·CLOCKS_PER_BIT cycles after the start-bit check.
- On the clock edge that takes the stop sample:
  - `byte_valid` pulses high for the following cycle.
  - `empty`, `count` and `rd_data` update in that same cycle.
  - Sticky flags are set in that same cycle.
- The FSM is back in IDLE half a bit before the stop bit ends, so back-to-back frames with no idle gap are received.
- A pop is registered: `rd_data` shows the next entry in the cycle after `rd_en`.
- All outputs are registered.

## Test plan
- CLOCKS_PER_BIT=16: send 8'h62 as 8N1 → one `byte_valid` pulse, `rd_data`=8'h62, `count`=1. After `rd_en`, `empty`=1.
- Send 8'hA5 with the stop bit forced to 0 → `framing_error`=1, FIFO stays empty. Assert `clear_errors` → `framing_error`=0 next cycle.
- Drive `rx_in` low for 4 cycles only → no `byte_valid`, no flags, FSM back in IDLE.
- Send 9 bytes (8'h00..8'h08) with no pops → `full`=1, `overflow`=1. Popping yields 8'h00..8'h07 in order.
- Send 8'h00 and 8'hFF back to back with no idle gap, popping on each `byte_valid` → both bytes are read correctly, `count` never exceeds 1, no flags.
- Assert `reset` during data bit 4 of a frame → all outputs return to their reset values. A subsequent 8'h3C frame is received correctly.
